bike_drive_sequencer: RTL
=========================

# bike_drive_sequencer

Motion sequencer ahead of the stepper SPWM motor driver in the bicycle drive. It debounces the rider's start, gear-up, gear-down and reverse buttons, and keeps a target gear. Toward that gear it ramps the driver's `division` (speed-gear) input one step per dwell interval. It also sequences safe stops and direction reversals: ramp down to gear 0, then change `direction` or drop `motor_en`.

## Interface
- `DEB_CYCLES`, default 16: consecutive synchronized-high cycles needed to accept a press (≥2).
- `DWELL_CYCLES`, default 64: cycles between successive gear steps while ramping (≥2).
- `clk` in 1: system clock; all logic on rising edge.
- `reset` in 1: asynchronous, active-low.
- `btn_start` in 1: raw run/stop button, active-high, asynchronous.
- `btn_up` in 1: raw gear-up button, active-high, asynchronous.
- `btn_down` in 1: raw gear-down button, active-high, asynchronous.
- `btn_rev` in 1: raw reverse button, active-high, asynchronous.
- `division` out 2: gear to the driver; 0 is slowest, 3 is fastest.
- `direction` out 1: 1 = forward, 0 = reverse.
- `motor_en` out 1: driver enable.
- `gear_target` out 2: current target gear.
- `busy` out 1: high in RAMP, BRAKE and STOP.
- `state` out 3: IDLE=0, RAMP=1, RUN=2, BRAKE=3, STOP=4.

## Operation
- **Reset values:** `division`=0, `direction`=1, `motor_en`=0, `gear_target`=0, `busy`=0, `state`=IDLE. All counters and synchronizers clear. Reset mid-ramp aborts immediately; there is no ramp-down.
- **Button front end:**
  - Each button passes through a 2-FF synchronizer, then a saturating stable-high counter.
  - The counter clears whenever the synchronized level is 0.
  - A one-cycle press pulse fires when the counter reaches DEB_CYCLES.
  - No further pulse fires until the level returns to 0.
- **Event priority per cycle:** start > rev > gear.
  - up and down pressed in the same cycle: both ignored.
  - A lower-priority event in the same cycle is dropped.
- **Target gear:** up gives `gear_target`+1, saturating at 3. down gives −1, saturating at 0. Gear events are accepted in every state.
- **IDLE:**
  - start → RAMP, with `motor_en`=1.
  - rev toggles `direction` immediately (next cycle).
- **RAMP:** every DWELL_CYCLES, `division` moves one step toward `gear_target`.
  - `division`==`gear_target` → RUN. This is checked every cycle, including on entry, so target 0 gives RUN one cycle after entry.
  - A target change mid-ramp redirects the ramp without restarting the dwell counter.
  - start → STOP. rev → BRAKE.
- **RUN:**
  - `gear_target`≠`division` → RAMP.
  - start → STOP. rev → BRAKE.
- **BRAKE:** step `division` down one per dwell until 0.
  - In the cycle `division` is 0, toggle `direction` → RAMP.
  - start → STOP; the pending reversal is cancelled.
  - rev is ignored.
- **STOP:** step down one per dwell until 0, then `motor_en`=0 → IDLE.
  - start and rev are ignored.
  - `gear_target` is kept for the next start.
- **Direction rule:** `direction` never changes while `motor_en`=1 and `division`≠0.

## Timing
- **Press latency:** raw rising edge to press pulse is 2+DEB_CYCLES cycles (input meeting setup). The FSM state and registered outputs update on the following edge.
- **Dwell counter:**
  - Loads 0 on entry to RAMP, BRAKE or STOP.
  - Increments every cycle while in those states.
  - On value DWELL_CYCLES−1 it performs one gear step and wraps to 0.
  - The first step comes DWELL_CYCLES cycles after entry.
  - The counter is held at 0 in IDLE and RUN.
- **Ramp duration:** a full 0→3 ramp takes 3×DWELL_CYCLES cycles, plus 1 cycle for the RAMP→RUN transition.
- **Registered outputs:** all outputs are registered. `busy` and `state` change in the same cycle as the state register.
- **Transition values:** the BRAKE→RAMP transition and the `direction` toggle occur on the same edge. `motor_en` falls on the same edge that STOP→IDLE.

## Test plan
Bench runs with DEB_CYCLES=4, DWELL_CYCLES=8.
1. **Debounce:** 3-cycle glitch on `btn_up` → no target change. 10-cycle press → `gear_target` 0→1 exactly 7 cycles after the raw edge. A held button gives one increment only.
2. **Ramp:** target 3, then start → RAMP. `division` goes 1, 2, 3 at 8, 16, 24 cycles after entry; RUN at cycle 25; `busy` low in RUN.
3. **Reverse in RUN at gear 2:** rev → BRAKE. `division` goes 1, then 0, at +8 and +16. `direction` goes 1→0 in the same cycle as RAMP entry. Re-ramp to 2 in 16 more cycles.
4. **Stop and saturation:** in RUN at gear 1, press up 4 times → `gear_target` saturates at 3. Then start → STOP. `division` reaches 0; `motor_en` drops; IDLE; `gear_target` stays 3.
5. **Simultaneous events:** start and rev in the same cycle during RUN → STOP, `direction` unchanged. up and down together → `gear_target` unchanged. rev in IDLE → `direction` toggles, `motor_en` stays 0.
6. **Reset mid-ramp:** assert `reset` low at `division`=2 during RAMP → all outputs take reset values asynchronously. After release, the FSM stays in IDLE until a new press.

Source files
------------

// File: rtl/bike_drive_sequencer_if.sv
// Button and drive-output bundle between the bicycle drive sequencer and its
// surroundings; the sequencer uses the slave modport.
interface bike_drive_sequencer_if;
  logic       btn_start;
  logic       btn_up;
  logic       btn_down;
  logic       btn_rev;
  logic [1:0] division;
  logic       direction;
  logic       motor_en;
  logic [1:0] gear_target;
  logic       busy;
  logic [2:0] state;

  modport master (
    output btn_start, btn_up, btn_down, btn_rev,
    input  division, direction, motor_en, gear_target, busy, state
  );

  modport slave (
    input  btn_start, btn_up, btn_down, btn_rev,
    output division, direction, motor_en, gear_target, busy, state
  );
endinterface

// File: rtl/bike_drive_sequencer.sv
// Debounces the rider buttons and ramps the SPWM driver's gear (division) toward
// a target, sequencing brake-and-reverse and ramp-down stops.
module bike_drive_sequencer #(
  parameter int DEB_CYCLES   = 16,
  parameter int DWELL_CYCLES = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  bike_drive_sequencer_if.slave  bus
);

  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int WW = $clog2(DWELL_CYCLES);
  localparam logic [DW-1:0] DEB_LAST   = DW'(DEB_CYCLES - 1);
  localparam logic [DW-1:0] DEB_SAT    = DW'(DEB_CYCLES);
  localparam logic [WW-1:0] DWELL_LAST = WW'(DWELL_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RAMP  = 3'd1,
    S_RUN   = 3'd2,
    S_BRAKE = 3'd3,
    S_STOP  = 3'd4
  } state_t;

  // Button bit order: 0 start, 1 up, 2 down, 3 rev
  logic [3:0]    w_btn;
  logic [3:0]    r_sync1, r_sync2, r_press;
  logic [DW-1:0] r_deb [4];

  state_t        r_state, w_state;
  logic [1:0]    r_division, w_division;
  logic          r_direction, w_direction;
  logic          r_motor_en, w_motor_en;
  logic [1:0]    r_gear_target, w_gear_target;
  logic          r_busy, w_busy;
  logic [WW-1:0] r_dwell, w_dwell;

  logic w_ev_start, w_ev_rev, w_ev_up, w_ev_down, w_gear_ok, w_step;

  assign w_btn = {bus.btn_rev, bus.btn_down, bus.btn_up, bus.btn_start};

  // Two-flop synchronizers and saturating stable-high counters; the press pulse
  // is registered the cycle the counter reaches DEB_CYCLES.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 4'b0000;
      r_sync2 <= 4'b0000;
      r_press <= 4'b0000;
      for (int i = 0; i < 4; i++) r_deb[i] <= '0;
    end else begin
      r_sync1 <= w_btn;
      r_sync2 <= r_sync1;
      for (int i = 0; i < 4; i++) begin
        if (!r_sync2[i]) r_deb[i] <= '0;
        else if (r_deb[i] != DEB_SAT) r_deb[i] <= r_deb[i] + DW'(1);
        r_press[i] <= r_sync2[i] && (r_deb[i] == DEB_LAST);
      end
    end
  end

  // Start outranks rev, which outranks gear; opposing gear presses cancel.
  assign w_ev_start = r_press[0];
  assign w_ev_rev   = r_press[3] & ~r_press[0];
  assign w_gear_ok  = ~r_press[0] & ~r_press[3] & ~(r_press[1] & r_press[2]);
  assign w_ev_up    = r_press[1] & w_gear_ok;
  assign w_ev_down  = r_press[2] & w_gear_ok;
  assign w_step     = (r_dwell == DWELL_LAST);

  // Next-state, next-output and dwell-counter logic
  always_comb begin
    w_state       = r_state;
    w_division    = r_division;
    w_direction   = r_direction;
    w_motor_en    = r_motor_en;
    w_gear_target = r_gear_target;
    w_busy        = 1'b0;
    w_dwell       = '0;

    if (w_ev_up && (r_gear_target != 2'd3)) w_gear_target = r_gear_target + 2'd1;
    else if (w_ev_down && (r_gear_target != 2'd0)) w_gear_target = r_gear_target - 2'd1;
    else w_gear_target = r_gear_target;

    case (r_state)
      S_IDLE: begin
        if (w_ev_start) begin
          w_state    = S_RAMP;
          w_motor_en = 1'b1;
        end else if (w_ev_rev) begin
          w_direction = ~r_direction;
        end else begin
          w_state = S_IDLE;
        end
      end
      S_RAMP: begin
        if (w_ev_start) w_state = S_STOP;
        else if (w_ev_rev) w_state = S_BRAKE;
        else if (r_division == r_gear_target) w_state = S_RUN;
        else if (w_step) begin
          if (r_division < r_gear_target) w_division = r_division + 2'd1;
          else w_division = r_division - 2'd1;
        end else begin
          w_state = S_RAMP;
        end
      end
      S_RUN: begin
        if (w_ev_start) w_state = S_STOP;
        else if (w_ev_rev) w_state = S_BRAKE;
        else if (r_division != r_gear_target) w_state = S_RAMP;
        else w_state = S_RUN;
      end
      S_BRAKE: begin
        if (w_ev_start) w_state = S_STOP;
        else if (r_division == 2'd0) begin
          w_state     = S_RAMP;
          w_direction = ~r_direction;
        end else if (w_step) w_division = r_division - 2'd1;
        else w_state = S_BRAKE;
      end
      S_STOP: begin
        if (r_division == 2'd0) begin
          w_state    = S_IDLE;
          w_motor_en = 1'b0;
        end else if (w_step) w_division = r_division - 2'd1;
        else w_state = S_STOP;
      end
      default: begin
        w_state    = S_IDLE;
        w_division = 2'd0;
        w_motor_en = 1'b0;
      end
    endcase

    // Dwell restarts on entry to any stepping state and wraps after each step
    if ((w_state == S_RAMP) || (w_state == S_BRAKE) || (w_state == S_STOP)) begin
      w_busy = 1'b1;
      if ((w_state != r_state) || w_step) w_dwell = '0;
      else w_dwell = r_dwell + WW'(1);
    end else begin
      w_busy  = 1'b0;
      w_dwell = '0;
    end
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_division    <= 2'd0;
      r_direction   <= 1'b1;
      r_motor_en    <= 1'b0;
      r_gear_target <= 2'd0;
      r_busy        <= 1'b0;
      r_dwell       <= '0;
    end else begin
      r_state       <= w_state;
      r_division    <= w_division;
      r_direction   <= w_direction;
      r_motor_en    <= w_motor_en;
      r_gear_target <= w_gear_target;
      r_busy        <= w_busy;
      r_dwell       <= w_dwell;
    end
  end

  assign bus.division    = r_division;
  assign bus.direction   = r_direction;
  assign bus.motor_en    = r_motor_en;
  assign bus.gear_target = r_gear_target;
  assign bus.busy        = r_busy;
  assign bus.state       = r_state;

endmodule
